count_extender: RTL

Downstream consumer of the 3-bit T-flip-flop binary counter. Samples the free-running 3-bit `count` every clock and detects 7→0 wraps. Extends the count with an EXT_WIDTH-bit wrap counter into a wider timestamp, and flags sequence errors and compare matches. Captures timestamp snapshots on request and holds them behind a valid/ready handshake for the next consumer.

---
 rtl/count_ext_pkg.sv | 23 ++
 rtl/count_extender_snap_holder.sv | 62 ++++++
 rtl/count_extender.sv | 134 +++++++++++++
 3 files changed

// File: rtl/count_ext_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : count_ext_pkg                                          |
// | Description : Shared widths and step classification for the          |
// |               count extender.                                        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package count_ext_pkg;

   localparam int          CNT_W   = 3;
   localparam logic [2:0]  CNT_MAX = 3'd7;

   // How one sampled upstream step relates to the previous sample
   typedef enum logic [2:0] {
      STEP_HOLD    = 3'd0,
      STEP_INC     = 3'd1,
      STEP_WRAP    = 3'd2,
      STEP_RESTART = 3'd3,
      STEP_ERR     = 3'd4
   } step_t;

endpackage
`default_nettype wire

// File: rtl/count_extender_snap_holder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : snap_holder                                            |
// | Description : FW-wide snapshot register held behind a valid/ready    |
// |               handshake, with a sticky overflow flag for requests    |
// |               that arrive while a snapshot is still pending.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module snap_holder
   import count_ext_pkg::*;
#(
   parameter int FW = 11
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          snap_req,
   input  logic          snap_ready,
   input  logic [FW-1:0] snap_in,
   output logic          snap_valid,
   output logic [FW-1:0] snap_data,
   output logic          snap_ovr
);

   logic          r_valid;
   logic [FW-1:0] r_data;
   logic          r_ovr;
   logic          w_accept;
   logic          w_free;

   // A slot frees up either when empty or when the consumer takes it this cycle
   assign w_accept = r_valid & snap_ready;
   assign w_free   = ~r_valid | w_accept;

   // Capture, release and overflow tracking; data only moves on a capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ovr   <= 1'b0;
      end else if (clear) begin
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (snap_req && w_free) begin
            r_data  <= snap_in;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (snap_req && !w_free) begin
            r_ovr <= 1'b1;
         end
      end
   end

   assign snap_valid = r_valid;
   assign snap_data  = r_data;
   assign snap_ovr   = r_ovr;

endmodule
`default_nettype wire

// File: rtl/count_extender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : count_extender                                         |
// | Description : Extends a free-running 3-bit upstream count with a     |
// |               wrap counter, flags illegal steps and compare matches, |
// |               and captures timestamp snapshots on request.           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module count_extender
   import count_ext_pkg::*;
#(
   parameter  int EXT_WIDTH = 8,
   localparam int FW        = EXT_WIDTH + CNT_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    count_in,
   input  logic          clear,
   input  logic [FW-1:0] match_val,
   input  logic          snap_req,
   input  logic          snap_ready,
   output logic          snap_valid,
   output logic [FW-1:0] snap_data,
   output logic [FW-1:0] value,
   output logic          wrap_pulse,
   output logic          match_pulse,
   output logic          seq_err,
   output logic          snap_ovr
);

   localparam logic [EXT_WIDTH-1:0] c_ext_one = EXT_WIDTH'(1);

   logic [CNT_W-1:0]     r_cnt;
   logic [EXT_WIDTH-1:0] r_ext;
   logic                 r_primed;
   logic                 r_seq_err;
   logic                 r_wrap;
   logic                 r_match;

   step_t                w_step;
   logic [CNT_W-1:0]     w_cnt_next;
   logic [EXT_WIDTH-1:0] w_ext_next;
   logic                 w_seq_next;
   logic                 w_wrap_next;
   logic                 w_match_next;
   logic [FW-1:0]        w_value;
   logic [FW-1:0]        w_value_next;

   assign w_value = {r_ext, r_cnt};

   // Classify the step from the held count to the freshly sampled one
   always_comb begin
      w_step = STEP_ERR;
      if (count_in == r_cnt) begin
         w_step = STEP_HOLD;
      end else if (r_cnt == CNT_MAX && count_in == 3'd0) begin
         w_step = STEP_WRAP;
      end else if (r_cnt != CNT_MAX && count_in == r_cnt + 3'd1) begin
         w_step = STEP_INC;
      end else if (count_in == 3'd0) begin
         // Only reachable from 1..6: upstream was reset mid-count
         w_step = STEP_RESTART;
      end
   end

   // Next extension, flag and pulse values; clear overrides any step effect
   always_comb begin
      // Every step adopts count_in (a hold already equals it)
      w_cnt_next  = count_in;
      w_ext_next  = r_ext;
      w_seq_next  = r_seq_err;
      w_wrap_next = 1'b0;
      if (clear) begin
         w_ext_next = '0;
         w_seq_next = 1'b0;
      end else if (r_primed) begin
         case (w_step)
            STEP_WRAP: begin
               w_ext_next  = r_ext + c_ext_one;
               w_wrap_next = 1'b1;
            end
            STEP_RESTART: w_ext_next = '0;
            STEP_ERR:     w_seq_next = 1'b1;
            default:      ;
         endcase
      end
   end

   assign w_value_next = {w_ext_next, w_cnt_next};

   // Edge-detect equality so a value parked on match_val fires only once
   assign w_match_next = !clear && r_primed &&
                         (w_value_next == match_val) && (w_value != match_val);

   // Extended value, priming, sticky error and one-cycle pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_ext     <= '0;
         r_primed  <= 1'b0;
         r_seq_err <= 1'b0;
         r_wrap    <= 1'b0;
         r_match   <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_ext     <= w_ext_next;
         r_primed  <= 1'b1;
         r_seq_err <= w_seq_next;
         r_wrap    <= w_wrap_next;
         r_match   <= w_match_next;
      end
   end

   snap_holder #(
      .FW         (FW)
   ) u_snap (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .snap_req   (snap_req),
      .snap_ready (snap_ready),
      .snap_in    (w_value_next),
      .snap_valid (snap_valid),
      .snap_data  (snap_data),
      .snap_ovr   (snap_ovr)
   );

   assign value       = w_value;
   assign wrap_pulse  = r_wrap;
   assign match_pulse = r_match;
   assign seq_err     = r_seq_err;

endmodule
`default_nettype wire
